// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM with debounced inc/dec duty buttons
//
// CH independent PWM outputs share one period counter. Duty targets are
// adjusted by debounced push-buttons on the channel picked by ch_sel and
// are copied into the active duty registers only at a period boundary.
// Edge- or center-aligned modulation is chosen by mode at a boundary.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       clock enable; when low every register holds
//   btn_inc   raw asynchronous increase button, active high
//   btn_dec   raw asynchronous decrease button, active high
//   ch_sel    channel targeted by button events (values >= CH ignored)
//   mode      0 = edge-aligned, 1 = center-aligned
//   pwm_out   registered PWM outputs, one per channel
//   pwm_sync  one-cycle pulse at every period start
module pwm_multi_ch #(
  parameter int PERIOD    = 10,
  parameter int CH        = 4,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 25000000,
  localparam int DW  = $clog2(PERIOD + 1),
  localparam int CW  = $clog2(2 * PERIOD),
  localparam int SW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int DVW = $clog2(DEB_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          btn_inc,
  input  logic          btn_dec,
  input  logic [SW-1:0] ch_sel,
  input  logic          mode,
  output logic [CH-1:0] pwm_out,
  output logic          pwm_sync
);

  // Debounce tick divider
  logic [DVW-1:0] div;
  logic           tick;

  assign tick = (div == DVW'(DEB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (ena) begin
      div <= tick ? '0 : div + DVW'(1);
    end
  end

  // Button synchronisers and debouncers
  logic [1:0] inc_sync, dec_sync;
  logic [1:0] inc_samp, dec_samp;
  logic       inc_deb, dec_deb;
  logic       inc_deb_q, dec_deb_q;
  logic       inc_ev, dec_ev;

  // Level follows the samples only when both agree; disagreement holds it.
  function automatic logic deb_next(input logic [1:0] s, input logic cur);
    if (s == 2'b11)      return 1'b1;
    else if (s == 2'b00) return 1'b0;
    else                 return cur;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_sync  <= '0;
      dec_sync  <= '0;
      inc_samp  <= '0;
      dec_samp  <= '0;
      inc_deb   <= 1'b0;
      dec_deb   <= 1'b0;
      inc_deb_q <= 1'b0;
      dec_deb_q <= 1'b0;
    end else if (ena) begin
      inc_sync  <= {inc_sync[0], btn_inc};
      dec_sync  <= {dec_sync[0], btn_dec};
      inc_deb_q <= inc_deb;
      dec_deb_q <= dec_deb;
      if (tick) begin
        // The level is decided from the sample pair being loaded this edge,
        // so the event appears one cycle after the second agreeing tick.
        inc_samp <= {inc_samp[0], inc_sync[1]};
        dec_samp <= {dec_samp[0], dec_sync[1]};
        inc_deb  <= deb_next({inc_samp[0], inc_sync[1]}, inc_deb);
        dec_deb  <= deb_next({dec_samp[0], dec_sync[1]}, dec_deb);
      end
    end
  end

  // Events stay asserted while ena is low, so a frozen event is applied
  // on the first enabled edge rather than dropped.
  assign inc_ev = inc_deb & ~inc_deb_q;
  assign dec_ev = dec_deb & ~dec_deb_q;

  // Duty targets and shadowed active duties
  logic [DW-1:0] target [CH];
  logic [DW-1:0] duty   [CH];

  function automatic logic [DW-1:0] inc_sat(input logic [DW-1:0] v);
    if (int'(v) + STEP >= PERIOD) return DW'(PERIOD);
    else                          return DW'(int'(v) + STEP);
  endfunction

  function automatic logic [DW-1:0] dec_sat(input logic [DW-1:0] v);
    if (int'(v) <= STEP) return '0;
    else                 return DW'(int'(v) - STEP);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        target[i] <= DW'(DUTY_INIT);
      end
    end else if (ena && (inc_ev ^ dec_ev)) begin
      // Selects outside 0..CH-1 match no channel and are ignored.
      for (int i = 0; i < CH; i++) begin
        if (ch_sel == SW'(i)) begin
          target[i] <= inc_ev ? inc_sat(target[i]) : dec_sat(target[i]);
        end
      end
    end
  end

  // Period counter, mode latch and shadow copy
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;
  logic          mode_q;
  logic          wrap;

  assign cnt_last = mode_q ? CW'(2 * PERIOD - 1) : CW'(PERIOD - 1);
  assign wrap     = (cnt == cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty[i] <= DW'(DUTY_INIT);
      end
    end else if (ena) begin
      if (wrap) begin
        cnt    <= '0;
        mode_q <= mode;
        for (int i = 0; i < CH; i++) begin
          duty[i] <= target[i];
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output decode, registered one cycle behind cnt
  logic [CW-1:0] tri_val;
  logic [CH-1:0] pwm_next;

  // Triangle folds the 2*PERIOD count back so center pulses are symmetric.
  assign tri_val = (cnt < CW'(PERIOD)) ? cnt : CW'(2 * PERIOD - 1) - cnt;

  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < CH; i++) begin
      if (mode_q) pwm_next[i] = (tri_val >= CW'(PERIOD) - CW'(duty[i]));
      else        pwm_next[i] = (cnt < CW'(duty[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out  <= '0;
      pwm_sync <= 1'b0;
    end else if (ena) begin
      pwm_out  <= pwm_next;
      pwm_sync <= (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - directed self-checking bench for pwm_multi_ch
module tb_pwm_multi_ch;

  localparam int PERIOD = 10;
  localparam int CH     = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       btn_inc;
  logic       btn_dec;
  logic [1:0] ch_sel;
  logic       mode;
  logic [3:0] pwm_out;
  logic       pwm_sync;

  int total = 0;
  int bad   = 0;

  pwm_multi_ch #(
    .PERIOD(PERIOD), .CH(CH), .STEP(1), .DUTY_INIT(5), .DEB_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .ch_sel(ch_sel), .mode(mode),
    .pwm_out(pwm_out), .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  // Per-period recorder: high count, first/last high position, period length
  int acc [CH];
  int fh [CH];
  int lh [CH];
  int done_cnt [CH];
  int first_hi [CH];
  int last_hi [CH];
  int pos = 0;
  int plen = 0;
  int periods = 0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      acc[c] = 0; fh[c] = -1; lh[c] = -1;
      done_cnt[c] = 0; first_hi[c] = -1; last_hi[c] = -1;
    end
  end

  always @(negedge clk) begin
    if (pwm_sync === 1'b1) begin
      for (int c = 0; c < CH; c++) begin
        done_cnt[c] = acc[c];
        first_hi[c] = fh[c];
        last_hi[c]  = lh[c];
        acc[c] = 0; fh[c] = -1; lh[c] = -1;
      end
      plen = pos;
      pos = 0;
      periods++;
    end
    for (int c = 0; c < CH; c++) begin
      if (pwm_out[c] === 1'b1) begin
        acc[c]++;
        if (fh[c] < 0) fh[c] = pos;
        lh[c] = pos;
      end
    end
    pos++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_period();
    int p0;
    int n;
    p0 = periods;
    n = 0;
    while (periods == p0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (periods == p0) begin
      total++;
      bad++;
      $error("FAIL sync_timeout: observed=no_sync expected=sync_within_100");
    end
  endtask

  task automatic press(input logic inc, input logic dec, input logic [1:0] sel);
    ch_sel  = sel;
    btn_inc = inc;
    btn_dec = dec;
    repeat (8) @(negedge clk);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_duty(input string tag, input int d0, input int d1, input int d2, input int d3);
    chk({tag, "_ch0"}, done_cnt[0], d0);
    chk({tag, "_ch1"}, done_cnt[1], d1);
    chk({tag, "_ch2"}, done_cnt[2], d2);
    chk({tag, "_ch3"}, done_cnt[3], d3);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
    ch_sel = 2'd0; mode = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_pwm_sync", pwm_sync, 0);

    // Basic edge mode: high 5 of 10, sync on the cnt=0 output cycle
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("edge_out_k%0d", k), pwm_out, (((k - 1) % 10) < 5) ? 4'hF : 4'h0);
      chk($sformatf("edge_sync_k%0d", k), pwm_sync, (((k - 1) % 10) == 0) ? 1 : 0);
    end

    // Increment ch2 mid-period: period B keeps 5, period C shows 6
    next_period();
    ch_sel = 2'd2;
    repeat (7) @(negedge clk);
    btn_inc = 1'b1;
    repeat (8) @(negedge clk);
    btn_inc = 1'b0;
    next_period();
    chk_duty("shadow_old", 5, 5, 5, 5);
    next_period();
    chk_duty("shadow_new", 5, 5, 6, 5);
    chk("edge_plen", plen, 10);

    // Saturate ch0 at PERIOD, clamp ch1 at 0
    for (int n = 0; n < 6; n++) press(1'b1, 1'b0, 2'd0);
    for (int n = 0; n < 12; n++) press(1'b0, 1'b1, 2'd1);
    next_period();
    next_period();
    chk_duty("clamp_a", 10, 0, 6, 5);
    next_period();
    chk_duty("clamp_b", 10, 0, 6, 5);

    // Simultaneous buttons and a one-cycle glitch leave ch3 alone
    press(1'b1, 1'b1, 2'd3);
    ch_sel = 2'd3;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    next_period();
    next_period();
    chk_duty("simul_glitch", 10, 0, 6, 5);

    // Center mode with ch0 at duty 3; mode change waits for the boundary
    for (int n = 0; n < 7; n++) press(1'b0, 1'b1, 2'd0);
    next_period();
    next_period();
    chk_duty("pre_center", 3, 0, 6, 5);
    next_period();
    repeat (3) @(negedge clk);
    mode = 1'b1;
    next_period();
    chk("mode_switch_plen", plen, 10);
    next_period();
    chk("center_plen", plen, 20);
    chk_duty("center", 6, 0, 12, 10);
    chk("center_first_ch0", first_hi[0], 7);
    chk("center_last_ch0", last_hi[0], 12);
    chk("center_first_ch2", first_hi[2], 4);
    chk("center_last_ch2", last_hi[2], 15);

    // Back to edge mode, ch0 to 8, then reset at cnt=4
    mode = 1'b0;
    next_period();
    next_period();
    chk("back_edge_plen", plen, 10);
    for (int n = 0; n < 5; n++) press(1'b1, 1'b0, 2'd0);
    next_period();
    next_period();
    chk_duty("pre_reset", 8, 0, 6, 5);
    next_period();
    repeat (3) @(negedge clk);
    chk("pre_reset_out", pwm_out, 4'b1101);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", pwm_out, 0);
    chk("async_reset_sync", pwm_sync, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_period();
    next_period();
    chk_duty("post_reset", 5, 5, 5, 5);
    chk("post_reset_plen", plen, 10);

    // ena low for 5 cycles while the cnt=1 output is showing
    next_period();
    @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    next_period();
    chk("ena_plen", plen, 15);
    chk("ena_hold_ch0", done_cnt[0], 10);
    chk("ena_hold_ch3", done_cnt[3], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
